goertzel_seq_ctrl: RTL and testbench

// - Run-level sequencer for the multi-bin Goertzel datapath (angle -> CORDIC -> NF Goertzel filters).
// - Per start pulse, it performs these steps in order:
//   - enable the angle/CORDIC coefficient stage;
//   - gate exactly NS samples into the filters via valid/ready;
//   - capture all NF bin results;
//   - stream the results out as an indexed valid/ready sequence.
// - Sits between the sample source / SPI register layer and the FourierTransform datapath.

---
 rtl/goertzel_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_goertzel_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_seq_ctrl.sv
// Run-level sequencer for the multi-bin Goertzel datapath: CORDIC enable, sample gating, bin capture, result stream.
// Define GSEQ_TIMEOUT_EN to add a watchdog on the CORDIC and DRAIN waits (limit TMO_CYC cycles).
module goertzel_seq_ctrl #(
    parameter  int NF      = 11,
    parameter  int NS      = 10,
    parameter  int TMO_CYC = 4096,
    localparam int IW      = (NF > 1) ? $clog2(NF) : 1,
    localparam int CW      = $clog2(NS + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              c_en_o,
    input  logic              cordic_vld_i,
    output logic              h_en_o,
    input  logic              smp_valid_i,
    output logic              smp_ready_o,
    input  logic [7:0]        smp_data_i,
    output logic [7:0]        smp_o,
    input  logic [NF-1:0]     bin_valid_i,
    input  logic [NF*32-1:0]  bin_data_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [IW-1:0]     res_idx_o,
    output logic [31:0]       res_data_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CORDIC,
        S_SAMPLE,
        S_DRAIN,
        S_DUMP
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [NF-1:0]   r_mask;
    logic [IW-1:0]   r_idx;
    logic [31:0]     r_buf [NF];
    logic [7:0]      r_smp;
    logic            r_done;

    logic            w_start;
    logic            w_smpHs;
    logic            w_lastSmp;
    logic [NF-1:0]   w_capture;
    logic            w_maskAll;
    logic            w_resHs;
    logic            w_lastRes;
    logic            w_timeout;

    assign w_start   = (r_state == S_IDLE) && start_i;
    assign w_smpHs   = (r_state == S_SAMPLE) && smp_valid_i;
    assign w_lastSmp = w_smpHs && (r_cnt == CW'(NS - 1));
    // Only bins not yet captured in this run are taken; repeats are dropped.
    assign w_capture = (r_state == S_DRAIN) ? (bin_valid_i & ~r_mask) : '0;
    assign w_maskAll = &(r_mask | w_capture);
    assign w_resHs   = (r_state == S_DUMP) && res_ready_i;
    assign w_lastRes = w_resHs && (r_idx == IW'(NF - 1));

`ifdef GSEQ_TIMEOUT_EN
    localparam int WW = $clog2(TMO_CYC + 1);

    logic [WW-1:0] r_wdog;
    logic          r_err;

    // Any state change restarts the count, so each CORDIC/DRAIN entry gets a full budget.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wdog <= '0;
        end else if (w_next != r_state) begin
            r_wdog <= '0;
        end else if (r_state == S_CORDIC || r_state == S_DRAIN) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_timeout = (r_wdog == WW'(TMO_CYC - 1)) &&
                       (((r_state == S_CORDIC) && !cordic_vld_i) ||
                        ((r_state == S_DRAIN) && !w_maskAll));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unusedTmo;

    assign w_timeout   = 1'b0;
    assign err_o       = 1'b0;
    assign w_unusedTmo = (TMO_CYC == 0);
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_CORDIC;
            end
            S_CORDIC: begin
                if (cordic_vld_i)   w_next = S_SAMPLE;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_SAMPLE: begin
                if (w_lastSmp) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_maskAll)      w_next = S_DUMP;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_DUMP: begin
                if (w_lastRes) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (r_state != S_IDLE);
        c_en_o      = (r_state == S_CORDIC);
        h_en_o      = (r_state == S_SAMPLE) || (r_state == S_DRAIN);
        smp_ready_o = (r_state == S_SAMPLE);
        res_valid_o = (r_state == S_DUMP);
        res_idx_o   = '0;
        res_data_o  = '0;
        if (r_state == S_DUMP) begin
            res_idx_o  = r_idx;
            res_data_o = r_buf[r_idx];
        end
    end

    assign done_o = r_done;
    assign smp_o  = r_smp;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_mask <= '0;
            r_idx  <= '0;
            r_smp  <= '0;
            r_done <= 1'b0;
            for (int i = 0; i < NF; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_done <= w_lastRes || w_timeout;

            if (w_start) begin
                r_cnt <= '0;
            end else if (w_smpHs) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_smpHs) begin
                r_smp <= smp_data_i;
            end

            if (w_start) begin
                r_mask <= '0;
            end else begin
                r_mask <= r_mask | w_capture;
            end

            for (int i = 0; i < NF; i++) begin
                if (w_capture[i]) begin
                    r_buf[i] <= bin_data_i[i*32 +: 32];
                end
            end

            if (w_start) begin
                r_idx <= '0;
            end else if (w_resHs) begin
                r_idx <= w_lastRes ? '0 : r_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_goertzel_seq_ctrl.sv
// Directed testbench for goertzel_seq_ctrl: nominal, gapped, staggered, backpressure, busy-start, reset runs.
// The timeout scenario is compiled in only when GSEQ_TIMEOUT_EN is defined.
module tb_goertzel_seq_ctrl;

    localparam int NF = 11;
    localparam int NS = 10;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              cEn;
    logic              cordicVld;
    logic              hEn;
    logic              smpValid;
    logic              smpReady;
    logic [7:0]        smpData;
    logic [7:0]        smpOut;
    logic [NF-1:0]     binValid;
    logic [NF*32-1:0]  binData;
    logic              resValid;
    logic              resReady;
    logic [3:0]        resIdx;
    logic [31:0]       resData;

    int                nChecks = 0;
    int                nPass   = 0;
    logic [31:0]       expv [NF];

    goertzel_seq_ctrl #(
        .NF      (NF),
        .NS      (NS),
        .TMO_CYC (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .c_en_o       (cEn),
        .cordic_vld_i (cordicVld),
        .h_en_o       (hEn),
        .smp_valid_i  (smpValid),
        .smp_ready_o  (smpReady),
        .smp_data_i   (smpData),
        .smp_o        (smpOut),
        .bin_valid_i  (binValid),
        .bin_data_i   (binData),
        .res_valid_o  (resValid),
        .res_ready_i  (resReady),
        .res_idx_o    (resIdx),
        .res_data_o   (resData)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL sim_watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "[TB] simulation hung");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Bin k carries k*mult+off, both on the bus and in the expected table.
    task automatic loadBins(input int mult, input int off);
        for (int k = 0; k < NF; k++) begin
            expv[k] = 32'(k * mult + off);
            binData[k*32 +: 32] = expv[k];
        end
    endtask

    // Start a run; cordic_vld_i arrives on the 5th CORDIC cycle. junkBins strobes every bin while in CORDIC.
    task automatic startRun(input bit junkBins);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("c_en_on", 32'(cEn), 32'd1);
        checkOutput("busy_on", 32'(busy), 32'd1);
        if (junkBins) binValid = '1;
        repeat (4) tick();
        binValid = '0;
        checkOutput("c_en_wait", 32'(cEn), 32'd1);
        checkOutput("h_en_cordic", 32'(hEn), 32'd0);
        cordicVld = 1'b1;
        tick();
        cordicVld = 1'b0;
        checkOutput("c_en_off", 32'(cEn), 32'd0);
        checkOutput("h_en_sample", 32'(hEn), 32'd1);
        checkOutput("smp_ready_on", 32'(smpReady), 32'd1);
    endtask

    // Feed samples 1..NS while ready is high; gapped toggles valid, startAt pulses start_i at that step.
    task automatic applyStimulus(input bit gapped, input int startAt);
        int          accepted;
        int          step;
        logic [7:0]  held;
        logic [7:0]  sent;
        bit          hs;
        accepted = 0;
        step     = 0;
        held     = smpOut;
        while (smpReady === 1'b1 && step < 60) begin
            smpValid = gapped ? ~step[0] : 1'b1;
            sent     = smpValid ? 8'(accepted + 1) : 8'hEE;
            smpData  = sent;
            start    = (step == startAt);
            hs       = smpValid;
            tick();
            if (hs) begin
                accepted++;
                held = sent;
            end
            checkOutput("smp_o", 32'(smpOut), 32'(held));
            step++;
        end
        smpValid = 1'b0;
        start    = 1'b0;
        checkOutput("accepted", 32'(accepted), 32'(NS));
        checkOutput("smp_ready_after", 32'(smpReady), 32'd0);
        checkOutput("h_en_drain", 32'(hEn), 32'd1);
        checkOutput("busy_drain", 32'(busy), 32'd1);
    endtask

    // Walk the result stream against expv, optionally holding ready low stallLen cycles at stallIdx.
    task automatic checkDump(input int stallIdx, input int stallLen);
        int idx;
        int stalls;
        int guard;
        idx    = 0;
        stalls = 0;
        guard  = 0;
        while (idx < NF && guard < 40) begin
            checkOutput("res_valid", 32'(resValid), 32'd1);
            checkOutput("res_idx", 32'(resIdx), 32'(idx));
            checkOutput("res_data", resData, expv[idx]);
            checkOutput("done_mid", 32'(done), 32'd0);
            if (idx == stallIdx && stalls < stallLen) begin
                resReady = 1'b0;
                stalls++;
            end else begin
                resReady = 1'b1;
                idx++;
            end
            tick();
            guard++;
        end
        resReady = 1'b0;
        checkOutput("res_valid_end", 32'(resValid), 32'd0);
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("busy_end", 32'(busy), 32'd0);
        tick();
        checkOutput("done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        rstn      = 1'b0;
        start     = 1'b0;
        cordicVld = 1'b0;
        smpValid  = 1'b0;
        smpData   = '0;
        binValid  = '0;
        binData   = '0;
        resReady  = 1'b0;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_c_en", 32'(cEn), 32'd0);
        checkOutput("rst_h_en", 32'(hEn), 32'd0);
        checkOutput("rst_smp_ready", 32'(smpReady), 32'd0);
        checkOutput("rst_smp_o", 32'(smpOut), 32'd0);
        checkOutput("rst_res_valid", 32'(resValid), 32'd0);
        checkOutput("rst_res_idx", 32'(resIdx), 32'd0);
        checkOutput("rst_res_data", resData, 32'd0);
        rstn = 1'b1;
        tick();

        $display("[TB] nominal run");
        loadBins(100, 0);
        startRun(1'b0);
        applyStimulus(1'b0, -1);
        smpValid = 1'b1;
        smpData  = 8'h55;
        binValid = '1;
        checkOutput("dump_early", 32'(resValid), 32'd0);
        tick();
        smpValid = 1'b0;
        binValid = '0;
        checkOutput("smp_hold_drain", 32'(smpOut), 32'd10);
        checkOutput("h_en_dump", 32'(hEn), 32'd0);
        checkDump(-1, 0);

        $display("[TB] gapped samples with result backpressure");
        loadBins(100, 1);
        startRun(1'b0);
        applyStimulus(1'b1, -1);
        binValid = '1;
        tick();
        binValid = '0;
        checkDump(4, 3);

        $display("[TB] staggered bins, start during SAMPLE, bins during CORDIC");
        loadBins(37, -500);
        startRun(1'b1);
        applyStimulus(1'b0, 4);
        for (int s = 0; s < NF; s++) begin
            checkOutput("no_dump_yet", 32'(resValid), 32'd0);
            binValid = '0;
            binValid[10-s] = 1'b1;
            if (s == 8) begin
                binValid[3] = 1'b1;
                binData[3*32 +: 32] = 32'h0BAD_F00D;
            end
            tick();
        end
        binValid = '0;
        checkOutput("dump_after_bin0", 32'(resValid), 32'd1);
        checkDump(-1, 0);

        $display("[TB] reset during DRAIN");
        loadBins(3, 9);
        startRun(1'b0);
        applyStimulus(1'b0, -1);
        binValid = 11'h03F;
        tick();
        binValid = '0;
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_h_en", 32'(hEn), 32'd0);
        checkOutput("mid_rst_smp_o", 32'(smpOut), 32'd0);
        checkOutput("mid_rst_res_valid", 32'(resValid), 32'd0);
        checkOutput("mid_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        loadBins(100, 2);
        startRun(1'b0);
        applyStimulus(1'b1, -1);
        binValid = '1;
        tick();
        binValid = '0;
        checkDump(-1, 0);

`ifdef GSEQ_TIMEOUT_EN
        $display("[TB] CORDIC watchdog timeout");
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("tmo_first", 32'(cEn), 32'd1);
        repeat (15) tick();
        checkOutput("tmo_c16_busy", 32'(busy), 32'd1);
        checkOutput("tmo_c16_err", 32'(err), 32'd0);
        tick();
        checkOutput("tmo_busy", 32'(busy), 32'd0);
        checkOutput("tmo_err", 32'(err), 32'd1);
        checkOutput("tmo_done", 32'(done), 32'd1);
        checkOutput("tmo_c_en", 32'(cEn), 32'd0);
        checkOutput("tmo_res_valid", 32'(resValid), 32'd0);
        tick();
        checkOutput("tmo_done_clear", 32'(done), 32'd0);
        checkOutput("tmo_err_sticky", 32'(err), 32'd1);
        loadBins(100, 3);
        startRun(1'b0);
        checkOutput("tmo_err_cleared", 32'(err), 32'd0);
        applyStimulus(1'b0, -1);
        binValid = '1;
        tick();
        binValid = '0;
        checkDump(-1, 0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
